conv_output_collector: RTL
==========================

Name: conv_output_collector

Overview:
- Downstream of the convolution system. Consumes its unthrottled output stream (value, valid, x, y, ch).
- Computes a linear result address for each value and buffers address and data in a small FIFO.
- Drains the FIFO to a result-memory write port with a valid/ready handshake.
- Reports completion once every output of a layer is written; flags lost samples, since the producer has no backpressure.

Parameters:
IO_DATA_WIDTH, 16, width of one output value
FEATURE_MAP_WIDTH, 1024, output feature map width (x range)
FEATURE_MAP_HEIGHT, 1024, output feature map height (y range)
OUTPUT_NB_CHANNELS, 64, output channels (ch range)
FIFO_DEPTH, 8, buffer entries, power of two, >=2
ADDR_WIDTH, $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS), result address width

Ports:
clk  in  1  clock
arst_in  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse that begins a layer collection
out  in  IO_DATA_WIDTH  signed output value from the convolution system
output_valid  in  1  out/x/y/ch valid this cycle
output_x  in  $clog2(FEATURE_MAP_WIDTH)  x coordinate
output_y  in  $clog2(FEATURE_MAP_HEIGHT)  y coordinate
output_ch  in  $clog2(OUTPUT_NB_CHANNELS)  channel
wr_addr  out  ADDR_WIDTH  result memory write address
wr_data  out  IO_DATA_WIDTH  result memory write data
wr_valid  out  1  write request
wr_ready  in  1  memory accepts write
done  out  1  all outputs of the layer written (sticky)
overflow  out  1  at least one sample dropped (sticky)
write_count  out  ADDR_WIDTH+1  writes completed this layer

Behaviour:
- Reset values (arst_in high, asynchronous):
  - state = IDLE, FIFO empty.
  - wr_valid = 0, wr_addr = 0, wr_data = 0.
  - done = 0, overflow = 0, write_count = 0.
- Reset mid-operation discards all buffered entries immediately.
- TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS.
- Address: addr = (output_y*FEATURE_MAP_WIDTH + output_x)*OUTPUT_NB_CHANNELS + output_ch.
  - Computed unsigned at full ADDR_WIDTH; no truncation before the final width.
- IDLE:
  - output_valid is ignored; nothing is pushed and overflow is not affected.
  - start -> COLLECT; clears write_count, done and overflow; flushes the FIFO.
- COLLECT:
  - Push: output_valid=1 and (FIFO not full, or a pop occurs in the same cycle) -> {addr, out} written at that clock edge.
  - Drop: output_valid=1, FIFO full and no pop -> sample dropped; overflow=1 from the next cycle.
  - Pop: wr_valid && wr_ready at a rising edge -> head entry removed; write_count increments.
  - Pop and push in the same cycle are both honoured; FIFO occupancy is unchanged.
  - Transition to DONE on the edge where write_count would reach TOTAL.
- Drain port (first-word-fall-through):
  - wr_valid = FIFO not empty, in COLLECT only.
  - wr_addr and wr_data reflect the head entry.
  - Latency: a sample pushed at edge N gives wr_valid=1 in the cycle after edge N, when the FIFO was empty.
  - While wr_valid=1 and wr_ready=0, wr_addr and wr_data hold stable.
- DONE:
  - done=1, wr_valid=0, further output_valid ignored.
  - start -> COLLECT, with the same clears as from IDLE.
- start in COLLECT restarts the layer: FIFO flushed, counters and flags cleared; it is not ignored.
- start takes priority over a simultaneous push/pop in that cycle; the push/pop is discarded.
- Overflow: a layer with drops never reaches TOTAL writes. done stays 0; the controller must re-issue start.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Test Plan:
Parameters for all scenarios: W=4, H=2, C=2 (TOTAL=16), FIFO_DEPTH=4.
1. Basic stream: start, 16 back-to-back valid outputs in raster order (ch fastest), wr_ready=1 -> 16 writes at addr 0..15 with matching data; done=1 one cycle after the 16th handshake; overflow=0.
2. Address mapping: single sample x=3, y=1, ch=1, out=-5 -> wr_addr=15, wr_data=16'hFFFB; write_count=1.
3. Backpressure: wr_ready=0 for 10 cycles while 4 samples arrive -> wr_valid held with a stable head (addr 0); no drop; on release the 4 writes occur in order.
4. Overflow: wr_ready=0 and 6 consecutive samples -> first 4 buffered, samples 5 and 6 dropped; overflow=1 from the cycle after sample 5; done never asserts.
5. Full with simultaneous pop: FIFO full, wr_ready=1 and output_valid=1 in the same cycle -> push accepted, occupancy stays 4, overflow stays 0.
6. Restart and reset: start mid-layer with 3 entries buffered -> FIFO empty, write_count=0, wr_valid=0 next cycle. arst_in pulse mid-write -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/conv_output_collector.sv
// Collects the convolution output stream into a small FWFT FIFO of {address, data}
// entries and drains it into a result memory write port; tracks completion and drops.
module conv_output_collector #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int ADDR_WIDTH         = $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS)
) (
  input  logic                                  clk,
  input  logic                                  arst_in,
  input  logic                                  start,
  input  logic [IO_DATA_WIDTH-1:0]              out,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic [ADDR_WIDTH-1:0]                 wr_addr,
  output logic [IO_DATA_WIDTH-1:0]              wr_data,
  output logic                                  wr_valid,
  input  logic                                  wr_ready,
  output logic                                  done,
  output logic                                  overflow,
  output logic [ADDR_WIDTH:0]                   write_count
);

  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam logic [ADDR_WIDTH:0] TOTAL_CNT = (ADDR_WIDTH+1)'(TOTAL);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t state_reg, state_next;

  logic [PTR_W:0]            wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]       write_count_reg;
  logic                      overflow_reg;
  logic [ADDR_WIDTH-1:0]     addr_mem [FIFO_DEPTH];
  logic [IO_DATA_WIDTH-1:0]  data_mem [FIFO_DEPTH];

  logic                      collecting, fifo_empty, fifo_full;
  logic                      pop, push, drop, last_write;
  logic [ADDR_WIDTH:0]       count_inc;
  logic [ADDR_WIDTH-1:0]     sample_addr;
  logic [PTR_W-1:0]          wr_idx, rd_idx;

  // Every term is widened to the full address width before any arithmetic.
  assign sample_addr = (ADDR_WIDTH'(output_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH)
                        + ADDR_WIDTH'(output_x)) * ADDR_WIDTH'(OUTPUT_NB_CHANNELS)
                       + ADDR_WIDTH'(output_ch);

  assign wr_idx     = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx     = rd_ptr_reg[PTR_W-1:0];
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);

  // A start pulse overrides any push or pop in the same cycle.
  assign collecting = (state_reg == COLLECT) && !start;
  assign pop        = collecting && !fifo_empty && wr_ready;
  assign push       = collecting && output_valid && (!fifo_full || pop);
  assign drop       = collecting && output_valid && fifo_full && !pop;
  assign count_inc  = write_count_reg + 1'b1;
  assign last_write = pop && (count_inc == TOTAL_CNT);

  always_comb begin
    state_next = state_reg;
    if (start)
      state_next = COLLECT;
    else if (state_reg == COLLECT && last_write)
      state_next = DONE;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      write_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (start) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      write_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg      <= rd_ptr_reg + 1'b1;
        write_count_reg <= count_inc;
      end
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= sample_addr;
      data_mem[wr_idx] <= out;
    end
  end

  assign wr_valid    = (state_reg == COLLECT) && !fifo_empty;
  assign wr_addr     = wr_valid ? addr_mem[rd_idx] : '0;
  assign wr_data     = wr_valid ? data_mem[rd_idx] : '0;
  assign done        = (state_reg == DONE);
  assign overflow    = overflow_reg;
  assign write_count = write_count_reg;

endmodule
